// File: rtl/nco_tone_gen_if.sv
// Stimulus-side bus of the NCO tone generator: control/tuning inputs and
// the sample stream that feeds the PLL input.
interface nco_tone_gen_if #(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 8
);
  logic               i_ce;
  logic               i_load;
  logic [PHASE_W-1:0] i_freq;
  logic               i_sync;
  logic [PHASE_W-1:0] i_phase_ofs;
  logic [OUT_W-1:0]   o_data;
  logic               o_valid;
  logic               o_wrap;

  modport master (
    output i_ce, i_load, i_freq, i_sync, i_phase_ofs,
    input  o_data, o_valid, o_wrap
  );

  modport slave (
    input  i_ce, i_load, i_freq, i_sync, i_phase_ofs,
    output o_data, o_valid, o_wrap
  );
endinterface

// File: rtl/nco_tone_gen.sv
// Phase-accumulator NCO producing a signed sine tone from a quarter-wave
// LUT. Accumulator stage plus three registered stages: decode, LUT read,
// sign/output. Retune and phase sync never flush samples already in flight.
module nco_tone_gen #(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 8
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  nco_tone_gen_if.slave   bus
);

  // Quarter-wave table: round(127*sin(2*pi*(k+0.5)/256)), k = 0..63.
  // The half-step offset makes the table symmetric under 63-k mirroring.
  function automatic logic [6:0] lut_f(input logic [5:0] addr);
    case (addr)
      6'd0:  lut_f = 7'd2;    6'd1:  lut_f = 7'd5;    6'd2:  lut_f = 7'd8;    6'd3:  lut_f = 7'd11;
      6'd4:  lut_f = 7'd14;   6'd5:  lut_f = 7'd17;   6'd6:  lut_f = 7'd20;   6'd7:  lut_f = 7'd23;
      6'd8:  lut_f = 7'd26;   6'd9:  lut_f = 7'd29;   6'd10: lut_f = 7'd32;   6'd11: lut_f = 7'd35;
      6'd12: lut_f = 7'd38;   6'd13: lut_f = 7'd41;   6'd14: lut_f = 7'd44;   6'd15: lut_f = 7'd47;
      6'd16: lut_f = 7'd50;   6'd17: lut_f = 7'd53;   6'd18: lut_f = 7'd56;   6'd19: lut_f = 7'd58;
      6'd20: lut_f = 7'd61;   6'd21: lut_f = 7'd64;   6'd22: lut_f = 7'd67;   6'd23: lut_f = 7'd69;
      6'd24: lut_f = 7'd72;   6'd25: lut_f = 7'd74;   6'd26: lut_f = 7'd77;   6'd27: lut_f = 7'd79;
      6'd28: lut_f = 7'd82;   6'd29: lut_f = 7'd84;   6'd30: lut_f = 7'd86;   6'd31: lut_f = 7'd89;
      6'd32: lut_f = 7'd91;   6'd33: lut_f = 7'd93;   6'd34: lut_f = 7'd95;   6'd35: lut_f = 7'd97;
      6'd36: lut_f = 7'd99;   6'd37: lut_f = 7'd101;  6'd38: lut_f = 7'd103;  6'd39: lut_f = 7'd105;
      6'd40: lut_f = 7'd106;  6'd41: lut_f = 7'd108;  6'd42: lut_f = 7'd110;  6'd43: lut_f = 7'd111;
      6'd44: lut_f = 7'd113;  6'd45: lut_f = 7'd114;  6'd46: lut_f = 7'd115;  6'd47: lut_f = 7'd117;
      6'd48: lut_f = 7'd118;  6'd49: lut_f = 7'd119;  6'd50: lut_f = 7'd120;  6'd51: lut_f = 7'd121;
      6'd52: lut_f = 7'd122;  6'd53: lut_f = 7'd123;  6'd54: lut_f = 7'd124;  6'd55: lut_f = 7'd124;
      6'd56: lut_f = 7'd125;  6'd57: lut_f = 7'd125;  6'd58: lut_f = 7'd126;  6'd59: lut_f = 7'd126;
      6'd60: lut_f = 7'd127;  6'd61: lut_f = 7'd127;  6'd62: lut_f = 7'd127;  6'd63: lut_f = 7'd127;
      default: lut_f = 7'd0;
    endcase
  endfunction

  // Magnitude plus sign flag to two's complement sample.
  function automatic logic [OUT_W-1:0] signed_sample_f(input logic [6:0] mag, input logic neg);
    logic [OUT_W-1:0] ext;
    ext = {{(OUT_W-7){1'b0}}, mag};
    signed_sample_f = neg ? ({OUT_W{1'b0}} - ext) : ext;
  endfunction

  logic [PHASE_W-1:0] acc_r;
  logic [PHASE_W-1:0] freq_r;
  logic [PHASE_W-1:0] step_base_s;
  logic [PHASE_W:0]   step_sum_s;

  logic [7:0]         p0_r;
  logic               v0_r;
  logic               w0_r;

  logic [1:0]         quad_s;
  logic [5:0]         fine_s;
  logic [5:0]         addr_s;
  logic [5:0]         lut_addr_r;
  logic               neg1_r;
  logic               v1_r;
  logic               w1_r;

  logic [6:0]         lut_q_r;
  logic               neg2_r;
  logic               v2_r;
  logic               w2_r;

  logic [OUT_W-1:0]   data_r;
  logic               valid_r;
  logic               wrap_r;

  // Phase of the sample being launched (sync overrides the accumulator) and its step.
  always_comb begin
    if (bus.i_sync) begin
      step_base_s = bus.i_phase_ofs;
    end else begin
      step_base_s = acc_r;
    end
    step_sum_s = {1'b0, step_base_s} + {1'b0, freq_r};
  end

  // Frequency register and phase accumulator; launches one sample per i_ce.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_r  <= {PHASE_W{1'b0}};
      freq_r <= {PHASE_W{1'b0}};
      p0_r   <= 8'd0;
      v0_r   <= 1'b0;
      w0_r   <= 1'b0;
    end else begin
      if (bus.i_load) begin
        freq_r <= bus.i_freq;
      end else begin
        freq_r <= freq_r;
      end
      if (bus.i_ce) begin
        acc_r <= step_sum_s[PHASE_W-1:0];
        p0_r  <= step_base_s[PHASE_W-1 -: 8];
        w0_r  <= step_sum_s[PHASE_W];
        v0_r  <= 1'b1;
      end else if (bus.i_sync) begin
        acc_r <= bus.i_phase_ofs;
        v0_r  <= 1'b0;
      end else begin
        v0_r  <= 1'b0;
      end
    end
  end

  // Quadrant decode: mirror the fine index in odd quadrants.
  always_comb begin
    quad_s = p0_r[7:6];
    fine_s = p0_r[5:0];
    if (quad_s[0]) begin
      addr_s = 6'd63 - fine_s;
    end else begin
      addr_s = fine_s;
    end
  end

  // Stage 1: register table address and sign.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lut_addr_r <= 6'd0;
      neg1_r     <= 1'b0;
      v1_r       <= 1'b0;
      w1_r       <= 1'b0;
    end else begin
      lut_addr_r <= addr_s;
      neg1_r     <= quad_s[1];
      v1_r       <= v0_r;
      w1_r       <= w0_r;
    end
  end

  // Stage 2: table read.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lut_q_r <= 7'd0;
      neg2_r  <= 1'b0;
      v2_r    <= 1'b0;
      w2_r    <= 1'b0;
    end else begin
      lut_q_r <= lut_f(lut_addr_r);
      neg2_r  <= neg1_r;
      v2_r    <= v1_r;
      w2_r    <= w1_r;
    end
  end

  // Stage 3: apply sign and publish; data holds between valid samples.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_r  <= {OUT_W{1'b0}};
      valid_r <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      if (v2_r) begin
        data_r  <= signed_sample_f(lut_q_r, neg2_r);
        valid_r <= 1'b1;
        wrap_r  <= w2_r;
      end else begin
        data_r  <= data_r;
        valid_r <= 1'b0;
        wrap_r  <= 1'b0;
      end
    end
  end

  assign bus.o_data  = data_r;
  assign bus.o_valid = valid_r;
  assign bus.o_wrap  = wrap_r;

endmodule

// File: tb/tb_nco_tone_gen.sv
// Self-checking bench for nco_tone_gen: a sine/phase model computes every
// expected sample; a compare process checks the outputs each cycle and
// directed tests pin the model with hand-computed samples.
module tb_nco_tone_gen;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b1;

  nco_tone_gen_if #(.PHASE_W(24), .OUT_W(8)) bus ();

  nco_tone_gen #(.PHASE_W(24), .OUT_W(8)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  initial forever #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Ideal sample for an 8-bit phase index, straight from the sine formula.
  function automatic int exp_sine(input int idx);
    real ang;
    real s;
    int  m;
    ang = 2.0 * 3.141592653589793 * (real'(idx) + 0.5) / 256.0;
    s   = $sin(ang);
    m   = $rtoi(((s < 0.0) ? -s : s) * 127.0 + 0.5);
    return (s < 0.0) ? -m : m;
  endfunction

  typedef struct {
    int due;
    int data;
    bit wrap;
  } exp_t;

  exp_t        eq[$];
  logic [23:0] m_acc = 24'd0;
  logic [23:0] m_freq = 24'd0;
  int          cyc = 0;
  int          e_valid = 0;
  int          e_wrap = 0;
  int          e_data = 0;

  // Model: each sample launched on edge N is due at the output after edge N+3.
  initial begin
    logic [23:0] ph;
    logic [24:0] nxt;
    exp_t        ent;
    forever begin
      @(posedge i_clk or negedge i_reset_n);
      if (!i_reset_n) begin
        m_acc = 24'd0; m_freq = 24'd0; eq.delete();
        e_valid = 0; e_wrap = 0; e_data = 0;
      end else begin
        cyc++;
        e_valid = 0; e_wrap = 0;
        if (eq.size() > 0 && eq[0].due == cyc) begin
          ent = eq.pop_front();
          e_valid = 1; e_wrap = int'(ent.wrap); e_data = ent.data;
        end
        if (bus.i_ce) begin
          ph  = bus.i_sync ? bus.i_phase_ofs : m_acc;
          nxt = {1'b0, ph} + {1'b0, m_freq};
          eq.push_back('{due: cyc + 3, data: exp_sine(int'(ph[23:16])), wrap: nxt[24]});
          m_acc = nxt[23:0];
        end else if (bus.i_sync) begin
          m_acc = bus.i_phase_ofs;
        end
        if (bus.i_load) m_freq = bus.i_freq;
      end
    end
  end

  int cap[1024];
  int capw[1024];
  int ncap = 0;

  // Compare process: outputs against the model every cycle, and log samples.
  initial forever begin
    @(negedge i_clk);
    chk("o_valid", int'(bus.o_valid), e_valid);
    chk("o_wrap", int'(bus.o_wrap), e_wrap);
    chk("o_data", int'($signed(bus.o_data)), e_data);
    if (bus.o_valid && ncap < 1024) begin
      cap[ncap]  = int'($signed(bus.o_data));
      capw[ncap] = int'(bus.o_wrap);
      ncap++;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    int b;
    int nw;
    bus.i_ce = 1'b1; bus.i_load = 1'b0; bus.i_sync = 1'b0;
    bus.i_freq = 24'h000000; bus.i_phase_ofs = 24'h000000;

    // Reset held with i_ce=1: outputs stay zero.
    #1 i_reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk("rst_valid", int'(bus.o_valid), 0);
      chk("rst_data", int'($signed(bus.o_data)), 0);
      chk("rst_wrap", int'(bus.o_wrap), 0);
    end
    i_reset_n = 1'b1;
    // First o_valid exactly after the third edge following the first i_ce edge.
    for (int i = 1; i <= 4; i++) begin
      @(negedge i_clk);
      chk("first_valid_latency", int'(bus.o_valid), (i == 4) ? 1 : 0);
    end
    chk("dc_sample", int'($signed(bus.o_data)), 2);
    chk("dc_no_wrap", int'(bus.o_wrap), 0);
    bus.i_ce = 1'b0;
    wait_neg(5);

    // Continuous run at 0x010000: one full period.
    bus.i_load = 1'b1; bus.i_freq = 24'h010000; bus.i_sync = 1'b1; bus.i_phase_ofs = 24'h000000;
    wait_neg(1);
    bus.i_load = 1'b0; bus.i_sync = 1'b0; bus.i_ce = 1'b1;
    b = ncap;
    wait_neg(258);
    bus.i_ce = 1'b0;
    wait_neg(5);
    chk("cont_count", ncap - b, 258);
    chk("cont_s0", cap[b], 2);
    chk("cont_s64", cap[b+64], 127);
    chk("cont_s128", cap[b+128], -2);
    chk("cont_s192", cap[b+192], -127);
    chk("cont_s256", cap[b+256], 2);
    chk("cont_wrap255", capw[b+255], 1);
    nw = 0;
    for (int i = 0; i < 258; i++) nw += capw[b+i];
    chk("cont_wrap_count", nw, 1);

    // Same setup, i_ce toggling.
    bus.i_sync = 1'b1; bus.i_phase_ofs = 24'h000000;
    wait_neg(1);
    bus.i_sync = 1'b0;
    b = ncap;
    for (int i = 0; i < 20; i++) begin
      bus.i_ce = 1'b1; wait_neg(1);
      bus.i_ce = 1'b0; wait_neg(1);
    end
    wait_neg(5);
    chk("tog_count", ncap - b, 20);
    chk("tog_s0", cap[b], 2);
    chk("tog_s1", cap[b+1], 5);
    chk("tog_s19", cap[b+19], 58);

    // Retune in the same cycle as a sample: phase-continuous.
    bus.i_sync = 1'b1; bus.i_phase_ofs = 24'h000000;
    wait_neg(1);
    bus.i_sync = 1'b0; bus.i_ce = 1'b1;
    b = ncap;
    wait_neg(10);
    bus.i_load = 1'b1; bus.i_freq = 24'h040000;
    wait_neg(1);
    bus.i_load = 1'b0;
    wait_neg(6);
    bus.i_ce = 1'b0;
    wait_neg(5);
    chk("retune_s9", cap[b+9], 29);
    chk("retune_s10", cap[b+10], 32);
    chk("retune_s11", cap[b+11], 35);
    chk("retune_s12", cap[b+12], 47);
    chk("retune_s13", cap[b+13], 58);

    // Sync with i_ce=1 to quarter phase.
    b = ncap;
    bus.i_sync = 1'b1; bus.i_phase_ofs = 24'h400000; bus.i_ce = 1'b1;
    wait_neg(1);
    bus.i_sync = 1'b0;
    wait_neg(1);
    bus.i_ce = 1'b0;
    wait_neg(5);
    chk("sync_s0", cap[b], 127);
    chk("sync_s1", cap[b+1], 126);

    // Reset mid-stream with samples in flight.
    bus.i_ce = 1'b1;
    wait_neg(5);
    chk("pre_rst_valid", int'(bus.o_valid), 1);
    #2 i_reset_n = 1'b0;
    #1;
    chk("rst_drop_valid", int'(bus.o_valid), 0);
    chk("rst_drop_data", int'($signed(bus.o_data)), 0);
    wait_neg(2);
    bus.i_ce = 1'b0; i_reset_n = 1'b1;
    b = ncap;
    wait_neg(6);
    chk("no_stale", ncap - b, 0);
    bus.i_ce = 1'b1;
    wait_neg(1);
    bus.i_ce = 1'b0;
    wait_neg(5);
    chk("post_rst_count", ncap - b, 1);
    chk("post_rst_s0", cap[b], 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nco_tone_gen.md
Name: nco_tone_gen

Overview:
- Phase-accumulator NCO that generates a signed 8-bit sine test tone.
- Serves as the stimulus source for the digital PLL. Its o_data drives the PLL's 8-bit i_data so the loop can lock to a known, programmable frequency and phase.
- Frequency and phase are loadable at run time.
- Quarter-wave LUT with a registered 3-stage output pipeline.

Parameters:
- PHASE_W, 24, phase accumulator and frequency word width. Must be ≥ 8.
- OUT_W, 8, output sample width in signed two's complement. Fixed at 8 for this release.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_ce  in  1  sample enable: one output sample per cycle in which i_ce=1.
- i_load  in  1  load i_freq into the frequency register.
- i_freq  in  PHASE_W  phase increment per sample (unsigned).
- i_sync  in  1  force the accumulator to i_phase_ofs.
- i_phase_ofs  in  PHASE_W  phase value applied on i_sync.
- o_data  out  8  signed sine sample.
- o_valid  out  1  o_data is a new sample (1-cycle pulse).
- o_wrap  out  1  accompanies the sample at which the accumulator overflowed.

Behaviour:
- Reset (async assert, sync release)
  - acc=0, freq_reg=0, all pipeline valid bits 0.
  - o_data=0, o_valid=0, o_wrap=0.
- Frequency register
  - i_load=1 → freq_reg<=i_freq on that edge.
  - A sample generated in the same cycle uses the old freq_reg; the new value takes effect from the next i_ce.
  - Loading does not disturb the phase (phase-continuous retune).
- Accumulator step, edge N with i_ce=1 and i_sync=0:
  - p0<=acc; acc<=acc+freq_reg, modulo 2^PHASE_W.
  - w0<=carry-out of that add; v0<=1.
- i_sync=1 (priority over normal step):
  - With i_ce=1: p0<=i_phase_ofs; acc<=i_phase_ofs+freq_reg; w0<=carry of that add; v0<=1.
  - With i_ce=0: acc<=i_phase_ofs; v0<=0.
- i_ce=0 and i_sync=0: acc holds; v0<=0.
- Stage 1, edge N+1
  - Decode q=p0[PHASE_W-1:PHASE_W-2] and a=p0[PHASE_W-3:PHASE_W-8] (6 bits); lower phase bits are truncated, no dithering.
  - Register lut_addr = (q[0] ? 63-a : a) and neg=q[1].
  - v1<=v0, w1<=w0.
- Stage 2, edge N+2
  - lut_q<=LUT[lut_addr] (unsigned 7-bit).
  - v2<=v1, w2<=w1, neg2<=neg.
- Stage 3, edge N+3
  - If v2: o_data<= neg2 ? -lut_q : +lut_q, sign-extended to 8 bits; o_valid<=1; o_wrap<=w2.
  - Else o_valid<=0, o_wrap<=0, and o_data holds its last value.
- Latency
  - Exactly 3 clocks from the i_ce edge to the o_valid edge.
  - Fully pipelined: one sample per clock at i_ce=1 continuous.
- LUT contents
  - 64 entries, LUT[k]=round(127*sin(2π(k+0.5)/256)), k=0..63.
  - Range 2..127. Output range is therefore ±127; -128 is never produced and the output never equals 0.
- Boundaries
  - Accumulator wraps modulo 2^PHASE_W silently; o_wrap flags it.
  - freq_reg=0 → constant sample value (DC), o_wrap never asserts.
  - In-flight samples are not flushed by i_sync or i_load; only reset clears the pipeline.
- Reset asserted mid-stream
  - Immediate return to reset values.
  - No o_valid for 3 clocks after the first i_ce following release.

Test Plan:
- Reset with i_ce=1 held → o_data=0, o_valid=0, o_wrap=0 throughout reset. The first o_valid occurs exactly 3 clocks after the first post-release i_ce edge.
- i_freq=0x010000, i_load, i_sync with ofs=0, then i_ce continuous → samples 0,64,128,192 = +2,+127,-2,-127. o_wrap=1 only on sample 255; period 256 samples.
- Same setup with i_ce toggling 1,0,1,0 → o_valid alternates. Sample sequence identical to the continuous run; o_data holds between valids.
- Retune: after 10 samples at 0x010000, i_load with i_freq=0x040000 in the same cycle as i_ce → that sample still uses the 0x010000 step. Subsequent phase steps are 4 LSBs of the 8-bit index; no phase jump.
- i_sync with i_phase_ofs=0x400000 and i_ce=1 → that sample=+127 (q=1, a=0). The following sample uses phase 0x400000+freq_reg.
- Reset asserted mid-stream with 3 samples in flight → o_valid drops immediately and no stale sample ever emerges after release.
